// File: rtl/strobe_period_meter.sv
// Measures the sys_clk spacing between rising edges of flag_in and compares it against EXP_DIV.
// Optional macro PERIOD_METER_SYNC_EN inserts a two-flop synchronizer ahead of the edge detector.
module strobe_period_meter #(
    parameter int CNT_W   = 16,
    parameter int EXP_DIV = 6
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             flag_in,
    input  logic             enable,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             ratio_ok,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] EXP_VAL = CNT_W'(EXP_DIV);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] period_nxt;
    logic             valid_nxt;
    logic             ratio_nxt;
    logic             timeout_nxt;
    logic             flag_src;
    logic             flag_d;
    logic             rise;

`ifdef PERIOD_METER_SYNC_EN
    logic sync_q1;
    logic sync_q2;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= flag_in;
            sync_q2 <= sync_q1;
        end
    end

    assign flag_src = sync_q2;
`else
    assign flag_src = flag_in;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            flag_d <= 1'b0;
        end else begin
            flag_d <= flag_src;
        end
    end

    assign rise = flag_src & ~flag_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
            ratio_ok     <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            period_out   <= period_nxt;
            period_valid <= valid_nxt;
            ratio_ok     <= ratio_nxt;
            timeout      <= timeout_nxt;
        end
    end

    // Dropping enable overrides every state, so a rise in that cycle is discarded.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        period_nxt  = period_out;
        valid_nxt   = 1'b0;
        ratio_nxt   = ratio_ok;
        timeout_nxt = timeout;

        if (!enable) begin
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            ratio_nxt   = 1'b0;
            timeout_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt   = '0;
                    state_nxt = ARM;
                end
                ARM: begin
                    if (rise) begin
                        cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
                        state_nxt = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_nxt  = cnt;
                        valid_nxt   = 1'b1;
                        ratio_nxt   = (cnt == EXP_VAL);
                        timeout_nxt = 1'b0;
                        cnt_nxt     = {{(CNT_W-1){1'b0}}, 1'b1};
                    end else if (cnt == CNT_MAX) begin
                        timeout_nxt = 1'b1;
                        cnt_nxt     = '0;
                        state_nxt   = ARM;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule
